// File: rtl/ustc_fan_collect.sv
// ustc_fan_collect
//   Collects one FAN output vector (NUM_IN lines) and drains its result
//   lines one per cycle, lowest line index first.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a FAN output vector is present on in
//   in_ready   collector is idle and can accept a vector
//   in         NUM_IN packed lines, line i at in[i*DW_LINE +: DW_LINE]
//              line = {ctrl, row, data}; ctrl[0]=valid, ctrl[1]=result
//   out_valid  a result is presented
//   out_ready  downstream accepts the result
//   out_data   data field of the presented line
//   out_row    row field of the presented line
//   out_idx    line position the result came from
//   out_last   final result of the current vector
module ustc_fan_collect #(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_DATA-1:0]        out_data,
  output logic [DW_ROW-1:0]         out_row,
  output logic [4:0]                out_idx,
  output logic                      out_last
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                      state, state_nxt;
  logic [NUM_IN*DW_LINE-1:0]   lines;
  logic [NUM_IN-1:0]           pending;
  logic [NUM_IN-1:0]           in_mask;
  logic [4:0]                  sel;
  logic                        accept;
  logic                        fire;
  logic                        one_left;
  logic [DW_LINE-1:0]          sel_line;

  // Only ctrl[1:0] of each line matter; the remaining ctrl bits are
  // intentionally ignored.
  logic unused_in;
  logic unused_sel_ctrl;
  assign unused_in       = ^in;
  assign unused_sel_ctrl = ^sel_line[DW_LINE-1:DW_DATA+DW_ROW];

  assign accept = in_valid && (state == IDLE);
  assign fire   = out_valid && out_ready;

  // Result-line mask of the incoming vector.
  always_comb begin
    in_mask = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_mask[i] = in[i*DW_LINE + DW_DATA + DW_ROW] &
                   in[i*DW_LINE + DW_DATA + DW_ROW + 1];
    end
  end

  // Lowest-indexed pending line.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (!found && pending[i]) begin
        sel   = 5'(i);
        found = 1'b1;
      end
    end
  end

  assign sel_line = lines[sel*DW_LINE +: DW_LINE];
  // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
  assign one_left = (pending != '0) &&
                    ((pending & (pending - NUM_IN'(1))) == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (in_mask != '0)) state_nxt = SCAN;
      SCAN: if (fire && one_left)           state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lines   <= '0;
      pending <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lines   <= in;
        pending <= in_mask;
      end else if (fire) begin
        pending <= pending & ~(NUM_IN'(1) << sel);
      end
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == SCAN);
    out_data  = '0;
    out_row   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = sel_line[DW_DATA-1:0];
      out_row  = sel_line[DW_DATA +: DW_ROW];
      out_idx  = sel;
      out_last = one_left;
    end
  end

endmodule
